// File: rtl/rv32_instr_encoder_if.sv
// ---------------------------------------------------------------------------
// rv32_instr_encoder_if
// Bundles the request and response handshakes of rv32_instr_encoder.
//   in_valid/in_ready  : request handshake (producer -> encoder)
//   in_kind, in_alusel : operation kind and R-type ALU select code
//   in_rd/rs1/rs2      : register indices
//   in_imm             : 13-bit signed immediate / byte offset
//   out_valid/out_ready: response handshake (encoder -> consumer)
//   out_instr          : 32-bit instruction word at the FIFO head
//   out_illegal        : head entry was illegal and replaced by a NOP
//   count              : occupied FIFO entries
// master = producer/consumer side, slave = encoder side.
// ---------------------------------------------------------------------------
interface rv32_instr_encoder_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic               in_valid;
    logic               in_ready;
    logic [1:0]         in_kind;
    logic [3:0]         in_alusel;
    logic [4:0]         in_rd;
    logic [4:0]         in_rs1;
    logic [4:0]         in_rs2;
    logic signed [12:0] in_imm;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_instr;
    logic               out_illegal;
    logic [CNT_W-1:0]   count;

    modport master (
        output in_valid, in_kind, in_alusel, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_illegal, count
    );

    modport slave (
        input  in_valid, in_kind, in_alusel, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_illegal, count
    );
endinterface

// File: rtl/rv32_instr_encoder.sv
// ---------------------------------------------------------------------------
// rv32_instr_encoder
// Encodes decoded operation fields (R-type ALU, LW, SW, BEQ) into RV32I
// instruction words and queues them in a DEPTH-entry FIFO.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset (clears FIFO control state)
//   bus  : rv32_instr_encoder_if.slave (request fields in, words out)
// Illegal requests are stored as addi x0,x0,0 with the illegal flag set.
// out_instr/out_illegal read 0 while the FIFO is empty.
// ---------------------------------------------------------------------------
module rv32_instr_encoder #(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    rv32_instr_encoder_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [6:0]  OP_R     = 7'b0110011;
    localparam logic [6:0]  OP_LOAD  = 7'b0000011;
    localparam logic [6:0]  OP_STORE = 7'b0100011;
    localparam logic [6:0]  OP_BR    = 7'b1100011;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    // Returns {illegal, word}; illegal requests collapse to the NOP.
    function automatic logic [32:0] encode(
        input logic [1:0]         kind,
        input logic [3:0]         alusel,
        input logic [4:0]         rd,
        input logic [4:0]         rs1,
        input logic [4:0]         rs2,
        input logic signed [12:0] imm
    );
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        bad;
        logic [31:0] w;
        f3  = 3'b000;
        f7  = 7'b0000000;
        bad = 1'b0;
        w   = '0;
        case (kind)
            2'b00: begin
                case (alusel)
                    4'b0000: f3 = 3'b000;
                    4'b0001: begin f3 = 3'b000; f7 = 7'b0100000; end
                    4'b0100: f3 = 3'b110;
                    4'b0101: f3 = 3'b111;
                    4'b0111: f3 = 3'b100;
                    4'b1000: f3 = 3'b001;
                    4'b1001: f3 = 3'b101;
                    4'b1010: begin f3 = 3'b101; f7 = 7'b0100000; end
                    4'b1101: f3 = 3'b010;
                    4'b1111: f3 = 3'b011;
                    default: bad = 1'b1;
                endcase
                w = {f7, rs2, rs1, f3, rd, OP_R};
            end
            2'b01: begin
                // 12-bit signed range: bits 12 and 11 must agree
                bad = imm[12] ^ imm[11];
                w   = {imm[11:0], rs1, 3'b010, rd, OP_LOAD};
            end
            2'b10: begin
                bad = imm[12] ^ imm[11];
                w   = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_STORE};
            end
            default: begin
                // branch offsets are halfword aligned
                bad = imm[0];
                w   = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OP_BR};
            end
        endcase
        return bad ? {1'b1, NOP} : {1'b0, w};
    endfunction

    logic [32:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [32:0]      enc_p0;

    // ---- stage p0: combinational encode of the request fields ----
    assign enc_p0 = encode(bus.in_kind, bus.in_alusel, bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_imm);

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    // in_ready depends only on count, so a full FIFO never accepts, even on a pop cycle
    assign push  = bus.in_valid && !full && !rst;
    assign pop   = bus.out_ready && !empty;

    // ---- stage p1: FIFO storage and head presentation ----
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= enc_p0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign bus.in_ready    = !full;
    assign bus.out_valid   = !empty;
    assign bus.out_instr   = empty ? 32'h0 : mem[rd_ptr][31:0];
    assign bus.out_illegal = empty ? 1'b0 : mem[rd_ptr][32];
    assign bus.count       = count;
endmodule

// File: doc/rv32_instr_encoder.md
# rv32_instr_encoder

Converts decoded operation fields (kind, ALU select code, register indices, immediate) back into 32-bit RV32I instruction words; it is the encoder counterpart to the opcode/funct decode path (`Control_unit` / `ALU_CU`). It feeds directed instruction streams into instruction memory or the core's fetch input for self-checking tests. Encoded words pass through a DEPTH-entry FIFO with valid/ready on both sides.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: request fields valid.
- `in_ready` output 1: FIFO can accept; equals !full.
- `in_kind` input 2: 00 R-type ALU, 01 load (LW), 10 store (SW), 11 branch (BEQ).
- `in_alusel` input 4: ALU select code (R-type only): 0000 add, 0001 sub, 0100 or, 0101 and, 0111 xor, 1000 sll, 1001 srl, 1010 sra, 1101 slt, 1111 sltu.
- `in_rd`, `in_rs1`, `in_rs2` input 5 each: register indices.
- `in_imm` input 13: signed immediate / byte offset.
- `out_valid` output 1: head entry valid.
- `out_ready` input 1: consumer takes head.
- `out_instr` output 32: encoded word at FIFO head; 0 when empty.
- `out_illegal` output 1: head entry was illegal and replaced by NOP.
- `count` output $clog2(DEPTH+1): occupied entries.

## Operation
- Encoding is combinational on the inputs; the 33-bit result {illegal, word} is written to the FIFO on accept (`in_valid && in_ready`).
- R-type: opcode 0110011. funct3: add/sub 000, sll 001, slt 010, sltu 011, xor 100, srl/sra 101, or 110, and 111. funct7 = 0100000 for sub/sra, else 0000000.
- Load: opcode 0000011, funct3 010, [31:20]=imm[11:0]. rs2 is ignored.
- Store: opcode 0100011, funct3 010, [31:25]=imm[11:5], [11:7]=imm[4:0]. rd is ignored.
- Branch: opcode 1100011, funct3 000, [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]. rd is ignored.
- Illegal cases store word 0x00000013 (addi x0,x0,0) with illegal=1:
  - R-type with an unlisted alusel.
  - Load or store with imm[12]≠imm[11] (out of 12-bit signed range).
  - Branch with imm[0]=1.
- FIFO behaviour:
  - Circular, with wr/rd pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
  - Pop on `out_valid && out_ready`.
  - Simultaneous push and pop when neither full nor empty: count unchanged, both pointers advance.
  - Full: `in_ready`=0 even if a pop occurs that cycle (no pass-through).
  - Empty: `out_valid`=0 and no pop; `out_ready` is ignored.
  - `in_valid` without `in_ready` is not accepted. Upstream holds its fields stable; the block does not check this.

## Timing
- Reset (asynchronous, takes effect immediately):
  - count=0, pointers=0, `out_valid`=0, `out_instr`=0, `out_illegal`=0, `in_ready`=1.
  - Inputs are ignored while `rst` is high.
- Reset mid-stream discards all entries; no partial word is emitted.
- Latency: a word accepted at edge N appears on `out_*` after edge N (1 cycle) when the FIFO was empty. Otherwise it appears after the entries ahead of it drain.
- Throughput: one accept and one emit per cycle.
- `out_instr` and `out_illegal` are driven from registered storage. No combinational path from `in_*` to `out_*`.
- `in_ready` depends only on count, not on `out_ready`.

## Test plan
- Fields (kind=00, alusel=0000, rd=3, rs1=1, rs2=2) -> `out_instr`=0x002081B3, illegal=0, one cycle after accept. Fields (kind=00, alusel=0001, rd=5, rs1=6, rs2=7) -> 0x407302B3.
- Load (rd=10, rs1=2, imm=-4) -> 0xFFC12503. Store (rs1=2, rs2=5, imm=8) -> 0x00512423. Branch (rs1=1, rs2=2, imm=16) -> 0x00208863.
- Illegal inputs, each -> 0x00000013 with `out_illegal`=1:
  - R-type alusel=0011.
  - Branch imm=17.
  - Load imm=0x0800 (+2048).
- Backpressure with `out_ready`=0:
  - Push 4 distinct words -> `in_ready` drops after the 4th accept and count=4; a 5th request is held, not lost.
  - Raise `out_ready` -> words emerge in order, one per cycle.
  - The 5th is accepted the cycle after the first pop.
- Run 10 cycles of continuous push+pop with count=2 -> count stays 2, pointers wrap past DEPTH, output order preserved.
- Assert `rst` asynchronously (mid-cycle) with count=3 -> immediately `out_valid`=0, `out_instr`=0, count=0. After release, the next push emits only the new word.
